// File: rtl/cheby_bus_initiator_pkg.sv
// Shared types for the Cheby bus initiator: FSM state encoding and the
// sizing helper for the Done-timeout counter.
package cheby_bus_initiator_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_FETCH  = 3'd1,
      WR_STROBE = 3'd2,
      WR_WAIT   = 3'd3,
      RD_STROBE = 3'd4,
      RD_WAIT   = 3'd5,
      RD_PUSH   = 3'd6,
      FINISH    = 3'd7
   } state_e;

   // Counter must be able to hold the timeout value itself.
   function automatic int timeout_cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/cheby_bus_initiator_if.sv
// Signal bundle between the burst initiator, its local command/data agents
// and the Cheby memory-slave bus.
interface cheby_bus_initiator_if #(
   parameter int G_ADDR_WIDTH = 6,
   parameter int G_DATA_WIDTH = 32
);

   // cmd/wr/rd streams: a word moves on a rising edge where valid and ready
   // are both 1; valid holds its payload until then, ready never waits on valid.
   logic                    cmd_valid_i;
   logic                    cmd_ready_o;
   logic                    cmd_write_i;
   logic [G_ADDR_WIDTH-1:0] cmd_addr_i;
   logic [G_ADDR_WIDTH:0]   cmd_len_i;
   logic [G_DATA_WIDTH-1:0] wr_data_i;
   logic                    wr_valid_i;
   logic                    wr_ready_o;
   logic [G_DATA_WIDTH-1:0] rd_data_o;
   logic                    rd_valid_o;
   logic                    rd_ready_i;
   logic                    busy_o;
   logic                    done_o;
   logic                    error_o;
   logic [G_ADDR_WIDTH-1:0] VMEAddr;
   logic [G_DATA_WIDTH-1:0] VMEWrData;
   logic                    VMERdMem;
   logic                    VMEWrMem;
   logic [G_DATA_WIDTH-1:0] VMERdData;
   logic                    VMERdDone;
   logic                    VMEWrDone;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
      input  wr_data_i, wr_valid_i, rd_ready_i,
      input  VMERdData, VMERdDone, VMEWrDone,
      output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
      output busy_o, done_o, error_o,
      output VMEAddr, VMEWrData, VMERdMem, VMEWrMem
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
      output wr_data_i, wr_valid_i, rd_ready_i,
      output VMERdData, VMERdDone, VMEWrDone,
      input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o,
      input  busy_o, done_o, error_o,
      input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem
   );

endinterface

// File: rtl/cheby_bus_initiator.sv
// Burst master for the Cheby VME-style memory-slave port: runs a read or
// write burst as single-word strobe/done transactions with a Done timeout.
module cheby_bus_initiator
   import cheby_bus_initiator_pkg::*;
#(
   parameter int G_ADDR_WIDTH = 6,
   parameter int G_DATA_WIDTH = 32,
   parameter int G_TIMEOUT    = 255
) (
   input  logic                  Clk,
   input  logic                  rst_n,
   cheby_bus_initiator_if.master bus,
   output state_e                dbg_state_o
);

   localparam int AW = G_ADDR_WIDTH;
   localparam int LW = G_ADDR_WIDTH + 1;
   localparam int DW = G_DATA_WIDTH;
   localparam int CW = timeout_cnt_width(G_TIMEOUT);
   localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(G_TIMEOUT);

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [LW-1:0]   rem_q, rem_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            abort_q, abort_d;

   logic            cmd_ready;
   logic            wr_ready;
   logic            rd_valid;
   logic            done_pulse;
   logic            error_pulse;
   logic            wr_mem;
   logic            rd_mem;
   logic [CW-1:0]   cnt_inc;
   logic            timed_out;
   logic            last_word;

   assign cnt_inc   = cnt_q + CW'(1);
   assign timed_out = (cnt_inc == TIMEOUT_LIMIT);
   assign last_word = (rem_q == LW'(1));

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;
      abort_d     = abort_q;
      cmd_ready   = 1'b0;
      wr_ready    = 1'b0;
      rd_valid    = 1'b0;
      done_pulse  = 1'b0;
      error_pulse = 1'b0;
      wr_mem      = 1'b0;
      rd_mem      = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            abort_d   = 1'b0;
            if (bus.cmd_valid_i) begin
               addr_d = bus.cmd_addr_i;
               rem_d  = bus.cmd_len_i;
               if (bus.cmd_len_i == '0) begin
                  state_d = FINISH;
               end else if (bus.cmd_write_i) begin
                  state_d = WR_FETCH;
               end else begin
                  state_d = RD_STROBE;
               end
            end
         end

         WR_FETCH: begin
            wr_ready = 1'b1;
            if (bus.wr_valid_i) begin
               wdata_d = bus.wr_data_i;
               state_d = WR_STROBE;
            end
         end

         WR_STROBE: begin
            wr_mem  = 1'b1;
            cnt_d   = '0;
            state_d = WR_WAIT;
         end

         // A read ack here is not ours and simply ages the timeout.
         WR_WAIT: begin
            if (bus.VMEWrDone) begin
               addr_d  = addr_q + AW'(1);
               rem_d   = rem_q - LW'(1);
               state_d = last_word ? FINISH : WR_FETCH;
            end else if (timed_out) begin
               abort_d = 1'b1;
               state_d = FINISH;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         RD_STROBE: begin
            rd_mem  = 1'b1;
            cnt_d   = '0;
            state_d = RD_WAIT;
         end

         RD_WAIT: begin
            if (bus.VMERdDone) begin
               rdata_d = bus.VMERdData;
               state_d = RD_PUSH;
            end else if (timed_out) begin
               abort_d = 1'b1;
               state_d = FINISH;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         // The next strobe waits for the consumer, so backpressure stalls the bus.
         RD_PUSH: begin
            rd_valid = 1'b1;
            if (bus.rd_ready_i) begin
               addr_d  = addr_q + AW'(1);
               rem_d   = rem_q - LW'(1);
               state_d = last_word ? FINISH : RD_STROBE;
            end
         end

         FINISH: begin
            done_pulse  = !abort_q;
            error_pulse = abort_q;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.cmd_ready_o = cmd_ready;
   assign bus.wr_ready_o  = wr_ready;
   assign bus.rd_valid_o  = rd_valid;
   assign bus.rd_data_o   = rdata_q;
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.done_o      = done_pulse;
   assign bus.error_o     = error_pulse;
   assign bus.VMEAddr     = addr_q;
   assign bus.VMEWrData   = wdata_q;
   assign bus.VMEWrMem    = wr_mem;
   assign bus.VMERdMem    = rd_mem;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_cheby_bus_initiator.sv
// Directed bench for cheby_bus_initiator: a behavioural memory slave with
// programmable ack latency, a bus monitor, and one task per scenario.
module tb_cheby_bus_initiator;
   import cheby_bus_initiator_pkg::*;

   localparam int AW   = 6;
   localparam int DW   = 32;
   localparam int TOUT = 10;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_e dbg_state;

   int checks = 0;
   int errors = 0;

   int slave_lat = 1;
   bit slave_en  = 1'b1;

   int done_cnt = 0;
   int err_cnt  = 0;
   int viol     = 0;
   bit bp_prev  = 1'b0;

   logic [AW-1:0] wr_addr_log[$];
   logic [DW-1:0] wr_data_log[$];
   logic [AW-1:0] rd_addr_log[$];
   logic [DW-1:0] exp_q[$];

   cheby_bus_initiator_if #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW)) bus ();

   cheby_bus_initiator #(
      .G_ADDR_WIDTH(AW),
      .G_DATA_WIDTH(DW),
      .G_TIMEOUT(TOUT)
   ) dut (
      .Clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog global time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return DW'(a) << 8;
   endfunction

   // ---------------- memory slave ----------------
   initial begin
      logic [AW-1:0] a;
      bit            is_rd;
      bus.VMERdDone = 1'b0;
      bus.VMEWrDone = 1'b0;
      bus.VMERdData = '0;
      forever begin
         @(posedge clk);
         #1;
         if (slave_en && rst_n && (bus.VMERdMem || bus.VMEWrMem)) begin
            is_rd = bus.VMERdMem;
            a     = bus.VMEAddr;
            repeat (slave_lat) @(posedge clk);
            #1;
            if (is_rd) begin
               bus.VMERdData = mem_word(a);
               bus.VMERdDone = 1'b1;
            end else begin
               bus.VMEWrDone = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.VMERdDone = 1'b0;
            bus.VMEWrDone = 1'b0;
            bus.VMERdData = '0;
         end
      end
   end

   // ---------------- bus monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.VMEWrMem) begin
            wr_addr_log.push_back(bus.VMEAddr);
            wr_data_log.push_back(bus.VMEWrData);
         end
         if (bus.VMERdMem) rd_addr_log.push_back(bus.VMEAddr);
         if (bus.VMEWrMem && bus.VMERdMem) viol++;
         if (bp_prev && bus.VMERdMem) viol++;
         if (bus.done_o) done_cnt++;
         if (bus.error_o) err_cnt++;
         bp_prev = bus.rd_valid_o && !bus.rd_ready_i;
      end else begin
         bp_prev = 1'b0;
      end
   end

   // ---------------- drivers ----------------
   task automatic clear_logs();
      wr_addr_log.delete();
      wr_data_log.delete();
      rd_addr_log.delete();
      exp_q.delete();
   endtask

   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW:0] l);
      int n = 0;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = w;
      bus.cmd_addr_i  = a;
      bus.cmd_len_i   = l;
      while (!bus.cmd_ready_o && n < 50) begin
         tick();
         n++;
      end
      tick();
      bus.cmd_valid_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bus.cmd_valid_i = 1'b0;
      bus.cmd_write_i = 1'b0;
      bus.cmd_addr_i  = '0;
      bus.cmd_len_i   = '0;
      bus.wr_data_i   = '0;
      bus.wr_valid_i  = 1'b0;
      bus.rd_ready_i  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.wr_ready_o !== 1'b0 ||
          bus.rd_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.error_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b busy=%b wrr=%b rdv=%b done=%b err=%b exp 1 0 0 0 0 0",
                  bus.cmd_ready_o, bus.busy_o, bus.wr_ready_o, bus.rd_valid_o, bus.done_o, bus.error_o);
      end
      checks++;
      if (bus.VMEAddr !== '0 || bus.VMEWrData !== '0 || bus.VMERdMem !== 1'b0 ||
          bus.VMEWrMem !== 1'b0 || bus.rd_data_o !== '0) begin
         errors++;
         $display("FAIL reset_bus got addr=%0h wd=%0h rdm=%b wrm=%b rd=%0h exp all 0",
                  bus.VMEAddr, bus.VMEWrData, bus.VMERdMem, bus.VMEWrMem, bus.rd_data_o);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (dbg_state !== IDLE || bus.cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_release got state=%0d rdy=%b exp state=0 rdy=1", dbg_state, bus.cmd_ready_o);
      end
   endtask

   task automatic test_write_burst();
      logic [DW-1:0] wdat[3];
      logic [AW-1:0] exp_a;
      int n = 0;
      int idx = 0;
      int d0 = done_cnt;
      wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33;
      slave_lat = 1;
      clear_logs();
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = wdat[0];
      send_cmd(1'b1, 6'd5, 7'd3);
      checks++;
      if (bus.busy_o !== 1'b1 || bus.cmd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL wr_busy_after_accept got busy=%b rdy=%b exp busy=1 rdy=0", bus.busy_o, bus.cmd_ready_o);
      end
      while (done_cnt == d0 && n < 200) begin
         if (bus.wr_ready_o && bus.wr_valid_i) begin
            tick();
            idx++;
            if (idx < 3) bus.wr_data_i = wdat[idx];
            else bus.wr_valid_i = 1'b0;
         end else begin
            tick();
         end
         n++;
      end
      bus.wr_valid_i = 1'b0;
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL wr_done_timeout got cycles=%0d exp <200", n);
      end
      checks++;
      if (wr_addr_log.size() != 3) begin
         errors++;
         $display("FAIL wr_strobe_count got %0d exp 3", wr_addr_log.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            exp_a = AW'(5 + i);
            checks++;
            if (wr_addr_log[i] !== exp_a || wr_data_log[i] !== wdat[i]) begin
               errors++;
               $display("FAIL wr_word%0d got addr=%0d data=%0h exp addr=%0d data=%0h",
                        i, wr_addr_log[i], wr_data_log[i], exp_a, wdat[i]);
            end
         end
      end
      checks++;
      if (done_cnt - d0 != 1 || bus.busy_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL wr_finish got dones=%0d busy=%b rdy=%b exp dones=1 busy=0 rdy=1",
                  done_cnt - d0, bus.busy_o, bus.cmd_ready_o);
      end
   endtask

   task automatic test_read_burst();
      logic [DW-1:0] exp;
      int n = 0;
      int cyc = 0;
      int d0 = done_cnt;
      int v0 = viol;
      slave_lat = 2;
      clear_logs();
      for (int i = 0; i < 4; i++) exp_q.push_back(DW'(i * 32'h100));
      send_cmd(1'b0, 6'd0, 7'd4);
      while (done_cnt == d0 && n < 300) begin
         bus.rd_ready_i = (cyc % 2 == 0);
         if (bus.rd_valid_o && bus.rd_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rd_extra_word got %0h exp none", bus.rd_data_o);
            end else begin
               exp = exp_q.pop_front();
               if (bus.rd_data_o !== exp) begin
                  errors++;
                  $display("FAIL rd_word got %0h exp %0h", bus.rd_data_o, exp);
               end
            end
         end
         tick();
         cyc++;
         n++;
      end
      bus.rd_ready_i = 1'b0;
      checks++;
      if (n >= 300 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rd_complete got cycles=%0d left=%0d exp <300 and 0", n, exp_q.size());
      end
      checks++;
      if (rd_addr_log.size() != 4 || viol != v0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL rd_bus got strobes=%0d viol=%0d dones=%0d exp 4 0 1",
                  rd_addr_log.size(), viol - v0, done_cnt - d0);
      end
   endtask

   task automatic test_read_wrap();
      logic [AW-1:0] exp_a[4];
      int n = 0;
      int d0 = done_cnt;
      exp_a[0] = 6'd62; exp_a[1] = 6'd63; exp_a[2] = 6'd0; exp_a[3] = 6'd1;
      slave_lat = 1;
      clear_logs();
      for (int i = 0; i < 4; i++) exp_q.push_back(mem_word(exp_a[i]));
      bus.rd_ready_i = 1'b1;
      send_cmd(1'b0, 6'd62, 7'd4);
      while (done_cnt == d0 && n < 200) begin
         if (bus.rd_valid_o && exp_q.size() != 0) begin
            checks++;
            if (bus.rd_data_o !== exp_q[0]) begin
               errors++;
               $display("FAIL wrap_data got %0h exp %0h", bus.rd_data_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         tick();
         n++;
      end
      bus.rd_ready_i = 1'b0;
      checks++;
      if (rd_addr_log.size() != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_count got strobes=%0d left=%0d exp 4 0", rd_addr_log.size(), exp_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_addr_log[i] !== exp_a[i]) begin
               errors++;
               $display("FAIL wrap_addr%0d got %0d exp %0d", i, rd_addr_log[i], exp_a[i]);
            end
         end
      end
   endtask

   task automatic test_len0();
      int d0 = done_cnt;
      clear_logs();
      send_cmd(1'b0, 6'd9, 7'd0);
      checks++;
      if (bus.done_o !== 1'b1 || bus.VMERdMem !== 1'b0 || bus.VMEWrMem !== 1'b0 || bus.cmd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL len0_finish got done=%b rdm=%b wrm=%b rdy=%b exp 1 0 0 0",
                  bus.done_o, bus.VMERdMem, bus.VMEWrMem, bus.cmd_ready_o);
      end
      tick();
      tick();
      checks++;
      if (bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 || done_cnt - d0 != 1 ||
          rd_addr_log.size() != 0 || wr_addr_log.size() != 0) begin
         errors++;
         $display("FAIL len0_after got done=%b rdy=%b dones=%0d strobes=%0d exp 0 1 1 0",
                  bus.done_o, bus.cmd_ready_o, done_cnt - d0, rd_addr_log.size() + wr_addr_log.size());
      end
   endtask

   task automatic test_timeout();
      logic [DW-1:0] got;
      bit early = 1'b0;
      bit got_word = 1'b0;
      int n = 0;
      int d0 = done_cnt;
      int e0 = err_cnt;
      slave_en = 1'b0;
      clear_logs();
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 32'hDEAD_0001;
      send_cmd(1'b1, 6'd20, 7'd2);
      while (!bus.VMEWrMem && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL to_strobe got cycles=%0d exp <20", n);
      end
      for (int i = 0; i < TOUT; i++) begin
         tick();
         if (bus.error_o || bus.done_o) early = 1'b1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL to_early got early_pulse=1 exp 0");
      end
      tick();
      checks++;
      if (bus.error_o !== 1'b1 || bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL to_pulse got err=%b done=%b rdy=%b exp 1 0 0", bus.error_o, bus.done_o, bus.cmd_ready_o);
      end
      tick();
      checks++;
      if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.wr_ready_o !== 1'b0 ||
          err_cnt - e0 != 1 || done_cnt != d0) begin
         errors++;
         $display("FAIL to_after got rdy=%b busy=%b wrr=%b errs=%0d dones=%0d exp 1 0 0 1 0",
                  bus.cmd_ready_o, bus.busy_o, bus.wr_ready_o, err_cnt - e0, done_cnt - d0);
      end
      bus.wr_valid_i = 1'b0;
      slave_en  = 1'b1;
      slave_lat = 1;
      bus.rd_ready_i = 1'b1;
      got = '0;
      n = 0;
      send_cmd(1'b0, 6'd3, 7'd1);
      while (done_cnt == d0 && n < 100) begin
         if (bus.rd_valid_o) begin
            got = bus.rd_data_o;
            got_word = 1'b1;
         end
         tick();
         n++;
      end
      bus.rd_ready_i = 1'b0;
      checks++;
      if (!got_word || got !== 32'h300 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL to_recover got word=%b data=%0h dones=%0d exp 1 300 1", got_word, got, done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid_burst();
      int n = 0;
      int idx = 0;
      int d0;
      int e0 = err_cnt;
      slave_lat = 3;
      clear_logs();
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 32'h100;
      send_cmd(1'b1, 6'd10, 7'd4);
      while (wr_addr_log.size() < 2 && n < 100) begin
         if (bus.wr_ready_o) begin
            tick();
            idx++;
            bus.wr_data_i = 32'h100 + idx;
         end else begin
            tick();
         end
         n++;
      end
      bus.wr_valid_i = 1'b0;
      checks++;
      if (dbg_state !== WR_WAIT) begin
         errors++;
         $display("FAIL rst_setup got state=%0d exp %0d", dbg_state, WR_WAIT);
      end
      d0 = done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.VMEAddr !== '0 ||
          bus.VMEWrData !== '0 || bus.wr_ready_o !== 1'b0 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL rst_async got rdy=%b busy=%b addr=%0h wd=%0h wrr=%b state=%0d exp 1 0 0 0 0 0",
                  bus.cmd_ready_o, bus.busy_o, bus.VMEAddr, bus.VMEWrData, bus.wr_ready_o, dbg_state);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (dbg_state !== IDLE || bus.busy_o !== 1'b0 || done_cnt != d0 || err_cnt != e0) begin
         errors++;
         $display("FAIL rst_late_done got state=%0d busy=%b dones=%0d errs=%0d exp 0 0 0 0",
                  dbg_state, bus.busy_o, done_cnt - d0, err_cnt - e0);
      end
      slave_lat = 1;
      clear_logs();
      n = 0;
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = 32'hCAFE_F00D;
      send_cmd(1'b1, 6'd1, 7'd1);
      while (done_cnt == d0 && n < 100) begin
         if (bus.wr_ready_o) begin
            tick();
            bus.wr_valid_i = 1'b0;
         end else begin
            tick();
         end
         n++;
      end
      bus.wr_valid_i = 1'b0;
      checks++;
      if (wr_addr_log.size() != 1 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL rst_fresh_count got strobes=%0d dones=%0d exp 1 1", wr_addr_log.size(), done_cnt - d0);
      end else begin
         checks++;
         if (wr_addr_log[0] !== 6'd1 || wr_data_log[0] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rst_fresh_word got addr=%0d data=%0h exp 1 cafef00d", wr_addr_log[0], wr_data_log[0]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write_burst();
      test_read_burst();
      test_read_wrap();
      test_len0();
      test_timeout();
      test_reset_mid_burst();
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL bus_protocol got violations=%0d exp 0", viol);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
